// File: rtl/direction_pkg.sv
// Shared direction encodings and helpers for the keypad-to-turn queue.
package direction_pkg;

   localparam int DIR_W = 4;

   localparam logic [DIR_W-1:0] DIR_NONE  = 4'b1111;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0001;
   localparam logic [DIR_W-1:0] DIR_UP    = 4'b0010;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0100;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b1000;

   function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] dir);
      case (dir)
         DIR_DOWN:  return DIR_UP;
         DIR_UP:    return DIR_DOWN;
         DIR_RIGHT: return DIR_LEFT;
         DIR_LEFT:  return DIR_RIGHT;
         default:   return DIR_NONE;
      endcase
   endfunction

   // With one bit per key, the one-hot vectors are exactly the four directions.
   function automatic logic dir_is_single(input logic [DIR_W-1:0] vec);
      return $countones(vec) == 1;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-bit counter debouncer for one player's four keys (1 = pressed).
module key_debouncer
   import direction_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIR_W-1:0] raw,
   output logic [DIR_W-1:0] level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt [DIR_W];

   // cnt holds the number of consecutive samples seen so far that disagree with level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level <= '0;
         for (int i = 0; i < DIR_W; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < DIR_W; i++) begin
            if (raw[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level[i] <= raw[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/direction_queue.sv
// Multi-player keypad front end: debounce, press detect, reversal filter,
// and a small turn FIFO per player drained one entry per move tick.
module direction_queue
   import direction_pkg::*;
#(
   parameter int PLAYERS         = 1,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int QUEUE_DEPTH     = 2,
   parameter int KEYS_ACTIVE_LOW = 1,
   localparam int CW             = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [DIR_W*PLAYERS-1:0] keys_hw,
   input  logic                     tick,
   input  logic                     enable,
   output logic [DIR_W*PLAYERS-1:0] direction,
   output logic [PLAYERS*CW-1:0]    queue_count,
   output logic [PLAYERS-1:0]       overflow
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam logic [DIR_W-1:0] POL = {DIR_W{KEYS_ACTIVE_LOW != 0}};
   localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [DIR_W-1:0] raw, level, prev, tail, ref_dir, dir_q;
      logic [DIR_W-1:0] mem [QUEUE_DEPTH];
      logic [PW-1:0]    rd_ptr, wr_ptr, tail_ptr;
      logic [CW-1:0]    count;
      logic             press, accept, full, pop, push, ovf;

      assign raw = keys_hw[p*DIR_W +: DIR_W] ^ POL;

      key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
         .clock (clock),
         .reset (reset),
         .raw   (raw),
         .level (level)
      );

      assign press    = (level != prev) && dir_is_single(level);
      assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
      assign tail     = mem[tail_ptr];
      // Compare against the last turn that will take effect, so queued turns chain correctly.
      assign ref_dir  = (count != '0) ? tail : dir_q;
      assign accept   = press && enable &&
                        (ref_dir == DIR_NONE ||
                         (level != ref_dir && level != dir_opposite(ref_dir)));
      assign full     = (count == CW'(QUEUE_DEPTH));
      assign pop      = tick && enable && (count != '0);
      assign push     = accept && (!full || pop);

      always_ff @(posedge clock) begin
         if (push) mem[wr_ptr] <= level;
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            prev   <= '0;
            dir_q  <= DIR_NONE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
         end else begin
            prev <= level;
            ovf  <= 1'b0;
            if (!enable) begin
               rd_ptr <= '0;
               wr_ptr <= '0;
               count  <= '0;
            end else begin
               if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
               if (pop) begin
                  dir_q  <= mem[rd_ptr];
                  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
               end
               if (push && !pop)      count <= count + 1'b1;
               else if (pop && !push) count <= count - 1'b1;
               ovf <= accept && full && !pop;
            end
         end
      end

      assign direction[p*DIR_W +: DIR_W] = dir_q;
      assign queue_count[p*CW +: CW]     = count;
      assign overflow[p]                 = ovf;
   end

endmodule

// File: tb/tb_direction_queue.sv
// Scoreboarded bench for direction_queue: two players, 4-cycle debounce, 2-deep queues.
module tb_direction_queue;

   localparam logic [3:0] NONE = 4'b1111, DOWN = 4'b0001, UP = 4'b0010,
                          RIGHT = 4'b0100, LEFT = 4'b1000;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       enable = 1'b1;
   logic [7:0] keys_hw = 8'hFF;
   logic [7:0] direction;
   logic [3:0] queue_count;
   logic [1:0] overflow;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q [$];
   logic       tick_seen = 1'b0;

   direction_queue #(
      .PLAYERS(2), .DEBOUNCE_CYCLES(4), .QUEUE_DEPTH(2), .KEYS_ACTIVE_LOW(1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .keys_hw     (keys_hw),
      .tick        (tick),
      .enable      (enable),
      .direction   (direction),
      .queue_count (queue_count),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Directions committed by a tick appear one cycle later; compare against the scoreboard.
   always @(posedge clock) tick_seen <= tick & enable;
   always @(negedge clock) begin
      if (tick_seen) begin
         if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
         else chk("dir_after_tick", direction, exp_q.pop_front());
      end
   end

   task automatic set_key(input int p, input logic [3:0] v);
      keys_hw[p*4 +: 4] = ~v;
   endtask

   task automatic press(input int p, input logic [3:0] v);
      set_key(p, v);
      repeat (5) @(negedge clock);
   endtask

   task automatic release_keys();
      keys_hw = 8'hFF;
      repeat (5) @(negedge clock);
   endtask

   task automatic do_tick(input logic [7:0] exp);
      exp_q.push_back(exp);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset_dir", direction, 8'hFF);
      chk("reset_count", queue_count, 4'h0);
      chk("reset_ovf", overflow, 2'b00);

      // 1: first press from NONE, committed on tick
      press(0, UP);
      chk("t1_count0", queue_count[1:0], 2'd1);
      chk("t1_dir_before_tick", direction, 8'hFF);
      release_keys();
      do_tick({NONE, UP});
      chk("t1_count_after_tick", queue_count, 4'h0);

      // 2: reversal rejected silently, perpendicular accepted
      press(0, DOWN);
      chk("t2_rev_count", queue_count[1:0], 2'd0);
      chk("t2_rev_ovf", overflow, 2'b00);
      release_keys();
      press(0, RIGHT);
      chk("t2_right_count", queue_count[1:0], 2'd1);
      release_keys();
      do_tick({NONE, RIGHT});

      // 3: double tap buffered, drained one per tick
      press(0, UP);
      release_keys();
      press(0, LEFT);
      chk("t3_count2", queue_count[1:0], 2'd2);
      release_keys();
      do_tick({NONE, UP});
      chk("t3_count1", queue_count[1:0], 2'd1);
      do_tick({NONE, LEFT});
      chk("t3_count0", queue_count[1:0], 2'd0);

      // 4: overflow on full queue, then full queue plus tick accepts
      press(0, UP);
      release_keys();
      press(0, LEFT);
      release_keys();
      press(0, DOWN);
      chk("t4_ovf_pulse", overflow, 2'b01);
      chk("t4_ovf_count", queue_count[1:0], 2'd2);
      @(negedge clock);
      chk("t4_ovf_clear", overflow, 2'b00);
      release_keys();
      set_key(0, DOWN);
      repeat (4) @(negedge clock);
      do_tick({NONE, UP});
      chk("t4_tick_no_ovf", overflow, 2'b00);
      chk("t4_tick_count", queue_count[1:0], 2'd2);
      release_keys();
      do_tick({NONE, LEFT});
      do_tick({NONE, DOWN});
      chk("t4_drained", queue_count, 4'h0);

      // 5: glitch and chord produce nothing; a long hold is one press
      set_key(0, LEFT);
      repeat (2) @(negedge clock);
      keys_hw = 8'hFF;
      repeat (6) @(negedge clock);
      chk("t5_glitch_count", queue_count, 4'h0);
      press(0, 4'b0101);
      chk("t5_chord_count", queue_count, 4'h0);
      chk("t5_chord_ovf", overflow, 2'b00);
      release_keys();
      press(1, UP);
      chk("t5_p1_count", queue_count, 4'b0100);
      repeat (45) @(negedge clock);
      chk("t5_hold_count", queue_count, 4'b0100);
      chk("t5_hold_ovf", overflow, 2'b00);
      release_keys();
      do_tick({UP, DOWN});
      chk("t5_after_tick", queue_count, 4'h0);

      // 6: enable drop flushes without touching direction; async reset
      press(0, LEFT);
      release_keys();
      press(0, UP);
      release_keys();
      chk("t6_count2", queue_count[1:0], 2'd2);
      enable = 1'b0;
      @(negedge clock);
      enable = 1'b1;
      chk("t6_flush_count", queue_count, 4'h0);
      chk("t6_flush_dir", direction, {UP, DOWN});
      set_key(0, RIGHT);
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      #1 chk("t6_async_dir", direction, 8'hFF);
      chk("t6_async_count", queue_count, 4'h0);
      keys_hw = 8'hFF;
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      chk("t6_post_reset_count", queue_count, 4'h0);
      chk("sb_leftover", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
